// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Parametrised raster timing generator running on clk_sys with a pixel
//   clock enable. Produces H/V position counters, blanking, sync, data
//   enable and line/frame strobes, plus a left-column blanking mask latched
//   once per frame and a registered, DE-gated copy of the incoming pixel.
//
// Ports
//   clk_sys     in   1      system clock (only clock)
//   reset       in   1      synchronous, active-high
//   ce_pix      in   1      pixel clock enable; state advances only when 1
//   lmask       in   4      columns 0..lmask-1 forced to blank, latched at frame start
//   rgb_in      in   RGB_W  pixel for the position being entered on this ce
//   rgb_out     out  RGB_W  rgb_in gated by de, registered
//   hpos        out  HW     current pixel column
//   vpos        out  VW     current line
//   hblank      out  1      horizontal blanking (includes left mask)
//   vblank      out  1      vertical blanking
//   hsync       out  1      horizontal sync, polarity from SYNC_POL
//   vsync       out  1      vertical sync, polarity from SYNC_POL
//   de          out  1      active video
//   line_start  out  1      one-cycle pulse on the ce entering hpos==0
//   frame_start out  1      one-cycle pulse on the ce entering (0,0)

module video_timing_gen #(
  parameter int H_ACTIVE = 256,
  parameter int H_TOTAL  = 318,
  parameter int HS_START = 283,
  parameter int HS_END   = 303,
  parameter int V_ACTIVE = 240,
  parameter int V_TOTAL  = 256,
  parameter int VS_START = 251,
  parameter int VS_END   = 254,
  parameter int SYNC_POL = 0,
  parameter int RGB_W    = 24,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic [3:0]       lmask,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [RGB_W-1:0] rgb_out,
  output logic [HW-1:0]    hpos,
  output logic [VW-1:0]    vpos,
  output logic             hblank,
  output logic             vblank,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic          SYNC_ON  = (SYNC_POL != 0);
  localparam logic          SYNC_OFF = ~SYNC_ON;

  logic [3:0]    lmask_q;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic          h_wrap;
  logic          v_wrap;
  logic          frame_next;
  logic [3:0]    lmask_next;
  logic          hblank_next;
  logic          vblank_next;
  logic          hsync_next;
  logic          vsync_next;
  logic          de_next;

  // Next-state position and all flags are derived from the position being
  // entered, so registered outputs line up with the new hpos/vpos.
  always_comb begin
    h_wrap      = (hpos == H_LAST);
    v_wrap      = (vpos == V_LAST);
    h_next      = h_wrap ? '0 : hpos + HW'(1);
    v_next      = vpos;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : vpos + VW'(1);
    end
    frame_next  = h_wrap && v_wrap;
    // The new mask already applies to line 0 of the frame that latches it.
    lmask_next  = frame_next ? lmask : lmask_q;
    hblank_next = (h_next >= HW'(H_ACTIVE)) || (32'(h_next) < 32'(lmask_next));
    vblank_next = (v_next >= VW'(V_ACTIVE));
    hsync_next  = ((h_next >= HW'(HS_START)) && (h_next < HW'(HS_END))) ? SYNC_ON : SYNC_OFF;
    vsync_next  = ((v_next >= VW'(VS_START)) && (v_next < VW'(VS_END))) ? SYNC_ON : SYNC_OFF;
    de_next     = ~hblank_next & ~vblank_next;
  end

  // Reset parks the counters on the last position so the first ce enters
  // (0,0). Without a ce everything holds except the strobes, which clear.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hpos        <= H_LAST;
      vpos        <= V_LAST;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      rgb_out     <= '0;
      lmask_q     <= '0;
    end else if (ce_pix) begin
      hpos        <= h_next;
      vpos        <= v_next;
      hblank      <= hblank_next;
      vblank      <= vblank_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      de          <= de_next;
      line_start  <= h_wrap;
      frame_start <= frame_next;
      rgb_out     <= de_next ? rgb_in : '0;
      lmask_q     <= lmask_next;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen. Two instances share all inputs: one with
// the default 318x256 raster, one with a tiny active-high-sync raster so
// that many frames, full-line masking and polarity are covered quickly.
module tb_video_timing_gen;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cePix = 1'b0;
   logic [3:0]  lmask = 4'd0;
   logic [23:0] rgbIn = 24'd0;

   logic [23:0] rgbOut0, rgbOut1;
   logic [8:0]  hpos0;
   logic [7:0]  vpos0;
   logic [4:0]  hpos1;
   logic [3:0]  vpos1;
   logic        hblank0, vblank0, hsync0, vsync0, de0, lineStart0, frameStart0;
   logic        hblank1, vblank1, hsync1, vsync1, de1, lineStart1, frameStart1;

   logic [63:0] obs0, obs1;
   logic [63:0] q0[$];
   logic [63:0] q1[$];

   int nCe[2];
   int lmq[2];
   logic [23:0] rgbq[2];
   int cyc = 0;
   int testsRun = 0;
   int testsFailed = 0;

   // 100 MHz system clock
   always #5 clock = ~clock;

   video_timing_gen dut (
      .clk_sys(clock), .reset(reset), .ce_pix(cePix), .lmask(lmask), .rgb_in(rgbIn),
      .rgb_out(rgbOut0), .hpos(hpos0), .vpos(vpos0), .hblank(hblank0), .vblank(vblank0),
      .hsync(hsync0), .vsync(vsync0), .de(de0), .line_start(lineStart0),
      .frame_start(frameStart0)
   );

   video_timing_gen #(
      .H_ACTIVE(12), .H_TOTAL(20), .HS_START(14), .HS_END(17),
      .V_ACTIVE(6), .V_TOTAL(10), .VS_START(7), .VS_END(8), .SYNC_POL(1), .RGB_W(24)
   ) dutSmall (
      .clk_sys(clock), .reset(reset), .ce_pix(cePix), .lmask(lmask), .rgb_in(rgbIn),
      .rgb_out(rgbOut1), .hpos(hpos1), .vpos(vpos1), .hblank(hblank1), .vblank(vblank1),
      .hsync(hsync1), .vsync(vsync1), .de(de1), .line_start(lineStart1),
      .frame_start(frameStart1)
   );

   // Pack every output of each instance into one word for comparison
   assign obs0 = {1'b0, 16'(hpos0), 16'(vpos0), hblank0, vblank0, hsync0, vsync0,
                  de0, lineStart0, frameStart0, rgbOut0};
   assign obs1 = {1'b0, 16'(hpos1), 16'(vpos1), hblank1, vblank1, hsync1, vsync1,
                  de1, lineStart1, frameStart1, rgbOut1};

   // Reference model: the position is derived from the number of enables
   // since reset rather than from a running counter.
   function automatic logic [63:0] model(input int idx, input int ht, input int ha,
                                         input int hss, input int hse, input int vt,
                                         input int va, input int vss, input int vse,
                                         input bit pol, input bit rst, input bit ce);
      int p, f, h, v;
      bit hb, vb, hs, vs, den, ls, fs;
      if (rst) begin
         nCe[idx] = 0;
         lmq[idx] = 0;
         rgbq[idx] = 24'd0;
      end else if (ce) begin
         nCe[idx]++;
      end
      if (nCe[idx] == 0) begin
         h = ht - 1; v = vt - 1;
         hb = 1'b1; vb = 1'b1; hs = !pol; vs = !pol; den = 1'b0; ls = 1'b0; fs = 1'b0;
      end else begin
         p = nCe[idx] - 1;
         f = p % (ht * vt);
         h = f % ht;
         v = f / ht;
         if (ce && f == 0) lmq[idx] = int'(lmask);
         hb  = (h >= ha) || (h < lmq[idx]);
         vb  = (v >= va);
         hs  = (h >= hss && h < hse) ? pol : !pol;
         vs  = (v >= vss && v < vse) ? pol : !pol;
         den = !hb && !vb;
         ls  = ce && (h == 0);
         fs  = ce && (f == 0);
         if (ce) rgbq[idx] = den ? rgbIn : 24'd0;
      end
      return {1'b0, 16'(h), 16'(v), hb, vb, hs, vs, den, ls, fs, rgbq[idx]};
   endfunction

   // Pop the expected result for the previous edge and compare (negedge sampling)
   task automatic checkOutput();
      logic [63:0] expv;
      if (q0.size() > 0) begin
         expv = q0.pop_front();
         testsRun++;
         assert (obs0 === expv) else begin
            testsFailed++;
            $error("[TB] FAIL dflt cyc=%0d observed=%h expected=%h", cyc, obs0, expv);
         end
      end
      if (q1.size() > 0) begin
         expv = q1.pop_front();
         testsRun++;
         assert (obs1 === expv) else begin
            testsFailed++;
            $error("[TB] FAIL small cyc=%0d observed=%h expected=%h", cyc, obs1, expv);
         end
      end
   endtask

   // Drive one clock of stimulus and push what each instance must show after it
   task automatic applyStimulus(input bit ce, input bit rst);
      @(negedge clock);
      checkOutput();
      cePix = ce;
      reset = rst;
      rgbIn = 24'($urandom);
      q0.push_back(model(0, 318, 256, 283, 303, 256, 240, 251, 254, 1'b0, rst, ce));
      q1.push_back(model(1, 20, 12, 14, 17, 10, 6, 7, 8, 1'b1, rst, ce));
      cyc++;
   endtask

   // Directed sequence: reset, full default frame with a mid-frame mask
   // change, sparse enables, full-line mask, reset with ce held high
   initial begin
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 81408 + 700; i++) begin
         if (i == 40000) lmask = 4'd5;
         applyStimulus(1'b1, 1'b0);
      end
      lmask = 4'd15;
      for (int i = 0; i < 1600; i++) applyStimulus((i % 8) == 0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 400; i++) applyStimulus(1'b1, 1'b0);
      @(negedge clock);
      checkOutput();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
